// File: rtl/sd_fifo_tx_fetcher.sv
// sd_fifo_tx_fetcher: transmit-path DMA front end. Issues single classic
// Wishbone reads from adr+offset and queues the returned words in a small
// first-word-fall-through FIFO drained by the SD data serializer.
module sd_fifo_tx_fetcher #(
   parameter int DEPTH     = 8,
   parameter int ADDR_STEP = 4,
   parameter int OFFSET_W  = 9
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] m_wb_adr_o,
   output logic        m_wb_we_o,
   output logic [3:0]  m_wb_sel_o,
   output logic        m_wb_cyc_o,
   output logic        m_wb_stb_o,
   input  logic [31:0] m_wb_dat_i,
   input  logic        m_wb_ack_i,
   output logic [2:0]  m_wb_cti_o,
   output logic [1:0]  m_wb_bte_o,
   input  logic        en,
   input  logic [31:0] adr,
   input  logic        rd,
   output logic [31:0] dat_o,
   output logic        empty,
   output logic        full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [OFFSET_W-1:0] STEP = OFFSET_W'(ADDR_STEP);

   localparam logic [1:0] ST_DISABLED = 2'd0;
   localparam logic [1:0] ST_READY    = 2'd1;
   localparam logic [1:0] ST_BUS      = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [AW:0]         count_q, count_d;
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;
   logic [31:0]         mem_q [DEPTH];
   logic                push, pop;

   // An ack only counts while enabled; en=0 flushes and discards it.
   assign push = en && (state_q == ST_BUS) && m_wb_ack_i;
   assign pop  = en && rd && (count_q != '0);

   // Next-state: FSM, FIFO pointers/occupancy and address offset.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      offset_d = offset_q;
      if (!en) begin
         state_d  = ST_DISABLED;
         count_d  = '0;
         wptr_d   = '0;
         rptr_d   = '0;
         offset_d = '0;
      end else begin
         case (state_q)
            ST_DISABLED: state_d = ST_READY;
            ST_READY:    if (count_q < FULL_CNT) state_d = ST_BUS;
            ST_BUS: begin
               if (m_wb_ack_i) begin
                  state_d  = ST_READY;
                  offset_d = offset_q + STEP;
               end
            end
            default:     state_d = ST_DISABLED;
         endcase
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_DISABLED;
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         offset_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         offset_q <= offset_d;
      end
   end

   // FIFO storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= m_wb_dat_i;
   end

   assign m_wb_adr_o = adr + {{(32-OFFSET_W){1'b0}}, offset_q};
   assign m_wb_cyc_o = (state_q == ST_BUS);
   assign m_wb_stb_o = m_wb_cyc_o;
   assign m_wb_we_o  = 1'b0;
   assign m_wb_sel_o = 4'b1111;
   assign m_wb_cti_o = 3'b000;
   assign m_wb_bte_o = 2'b00;

   assign dat_o = mem_q[rptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

endmodule

// File: tb/tb_sd_fifo_tx_fetcher.sv
// Bench for sd_fifo_tx_fetcher: queue-based reference model, a per-cycle
// compare process, directed scenarios with literal expectations, and a
// randomized phase with random wait states, pops and enable drops.
module tb_sd_fifo_tx_fetcher;
   localparam int DEPTH     = 8;
   localparam int ADDR_STEP = 4;
   localparam int OFFSET_W  = 9;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_wb_adr_o;
   logic        m_wb_we_o;
   logic [3:0]  m_wb_sel_o;
   logic        m_wb_cyc_o, m_wb_stb_o;
   logic [31:0] m_wb_dat_i;
   logic        m_wb_ack_i;
   logic [2:0]  m_wb_cti_o;
   logic [1:0]  m_wb_bte_o;
   logic        en;
   logic [31:0] adr;
   logic        rd;
   logic [31:0] dat_o;
   logic        empty, full;

   sd_fifo_tx_fetcher #(.DEPTH(DEPTH), .ADDR_STEP(ADDR_STEP), .OFFSET_W(OFFSET_W)) dut (
      .clk(clk), .rst(rst),
      .m_wb_adr_o(m_wb_adr_o), .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o),
      .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_dat_i(m_wb_dat_i),
      .m_wb_ack_i(m_wb_ack_i), .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o),
      .en(en), .adr(adr), .rd(rd), .dat_o(dat_o), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: enabled flag, outstanding-request flag, word queue, offset.
   bit          m_en, m_busy;
   logic [31:0] m_q[$];
   int          m_off;
   int          m_sz;
   bit          m_push, m_pop, m_start;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_en = 0; m_busy = 0; m_q.delete(); m_off = 0;
      end else if (!en) begin
         m_en = 0; m_busy = 0; m_q.delete(); m_off = 0;
      end else if (!m_en) begin
         m_en = 1;
      end else begin
         m_sz    = m_q.size();
         m_push  = m_busy && m_wb_ack_i;
         m_pop   = rd && (m_sz > 0);
         m_start = !m_busy && (m_sz < DEPTH);
         if (m_pop)  void'(m_q.pop_front());
         if (m_push) m_q.push_back(m_wb_dat_i);
         if (m_push) begin
            m_busy = 0;
            m_off  = (m_off + ADDR_STEP) % (1 << OFFSET_W);
         end else if (m_start) begin
            m_busy = 1;
         end
      end
   end

   // Per-cycle compare of every output against the model.
   bit chk_on = 0;
   always @(negedge clk) begin
      if (!rst && chk_on) begin
         chk("cyc", m_wb_cyc_o, m_busy);
         chk("stb", m_wb_stb_o, m_busy);
         chk("we", m_wb_we_o, 0);
         chk("sel", m_wb_sel_o, 4'hF);
         chk("cti", m_wb_cti_o, 0);
         chk("bte", m_wb_bte_o, 0);
         chk("adr_o", m_wb_adr_o, adr + 32'(m_off));
         chk("empty", empty, m_q.size() == 0);
         chk("full", full, m_q.size() == DEPTH);
         if (m_q.size() > 0) chk("dat_o", dat_o, m_q[0]);
      end
   end

   // Stimulus: memory responder and consumer, driven just after the falling edge.
   int          ack_mode = 0;  // 0: ack next edge, 1: random waits, 2: never
   int          rd_mode  = 0;  // 0: no pops, 1: rd held high, 2: random
   int          n_acks   = 0;
   logic [31:0] next_val = 32'h11;
   logic [31:0] last_adr = '0, prev_adr = '0;

   task automatic tick();
      @(negedge clk); #1;
      m_wb_ack_i = 1'b0;
      m_wb_dat_i = $urandom;
      case (ack_mode)
         0:       m_wb_ack_i = m_wb_cyc_o;
         1:       m_wb_ack_i = m_wb_cyc_o ? ($urandom % 3 == 0) : ($urandom % 6 == 0);
         default: m_wb_ack_i = 1'b0;
      endcase
      if (ack_mode == 0) m_wb_dat_i = next_val;
      if (m_wb_ack_i && m_wb_cyc_o && en) begin
         n_acks++;
         prev_adr = last_adr;
         last_adr = m_wb_adr_o;
         next_val = next_val + 32'h11;
      end
      rd = (rd_mode == 0) ? 1'b0 : (rd_mode == 1) ? 1'b1 : 1'($urandom % 2);
   endtask

   task automatic wait_cyc(input string nm);
      int k = 0;
      while (!m_wb_cyc_o && k < 200) begin tick(); k++; end
      chk(nm, m_wb_cyc_o, 1);
   endtask

   initial begin
      rst = 1; en = 0; adr = 32'h1000; rd = 0; m_wb_ack_i = 0; m_wb_dat_i = 0;
      #1;
      chk("rst cyc", m_wb_cyc_o, 0);
      chk("rst stb", m_wb_stb_o, 0);
      chk("rst we", m_wb_we_o, 0);
      chk("rst empty", empty, 1);
      chk("rst full", full, 0);
      chk("rst adr", m_wb_adr_o, 32'h1000);
      repeat (2) @(negedge clk);
      #1 rst = 0;
      chk_on = 1;

      // Fill without pops: 8 transfers then idle while full.
      en = 1; ack_mode = 0; rd_mode = 0; n_acks = 0; next_val = 32'h11;
      repeat (40) tick();
      chk("fill count", n_acks, 8);
      chk("fill last adr", last_adr, 32'h101C);
      chk("fill full", full, 1);
      chk("fill cyc idle", m_wb_cyc_o, 0);
      chk("fill head", dat_o, 32'h11);
      // One pop frees one slot: exactly one more transfer at 0x1020.
      rd = 1; tick();
      chk("pop1 head", dat_o, 32'h22);
      repeat (10) tick();
      chk("refill count", n_acks, 9);
      chk("refill adr", last_adr, 32'h1020);
      chk("refill full", full, 1);
      rd = 1; tick();
      chk("pop2 head", dat_o, 32'h33);

      // Offset wrap: 129th transfer lands on the base address again.
      en = 0; tick(); tick();
      adr = 32'h2000; en = 1; rd_mode = 1; n_acks = 0;
      begin
         int k = 0;
         while (n_acks < 129 && k < 2000) begin tick(); k++; end
      end
      chk("wrap count", n_acks, 129);
      chk("wrap adr 128", prev_adr, 32'h21FC);
      chk("wrap adr 129", last_adr, 32'h2000);

      // en dropped on the same edge as an ack.
      en = 0; tick();
      adr = 32'h3000; en = 1; rd_mode = 0; ack_mode = 0;
      repeat (12) tick();
      ack_mode = 2;
      wait_cyc("drop cyc rise");
      en = 0; m_wb_ack_i = 1; m_wb_dat_i = 32'hDEADBEEF;
      tick();
      chk("drop cyc", m_wb_cyc_o, 0);
      chk("drop empty", empty, 1);
      chk("drop adr", m_wb_adr_o, 32'h3000);
      en = 1; rd_mode = 1;
      wait_cyc("reen cyc rise");
      chk("reen adr", m_wb_adr_o, 32'h3000);
      ack_mode = 0;
      repeat (30) tick();

      // Randomized phase.
      ack_mode = 1; rd_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (i % 200 == 0) rd_mode = $urandom_range(0, 2);
         if ($urandom % 60 == 0) begin
            en = 0;
            if ($urandom % 2 == 0) adr = $urandom & 32'hFFFF_FFFC;
         end else begin
            en = 1;
         end
      end

      // Asynchronous reset while full.
      en = 1; rd_mode = 0; ack_mode = 0;
      repeat (40) tick();
      chk("pre-rst full", full, 1);
      #2 rst = 1;
      #1;
      chk("arst full", full, 0);
      chk("arst empty", empty, 1);
      chk("arst cyc", m_wb_cyc_o, 0);
      chk("arst adr", m_wb_adr_o, adr);
      @(negedge clk); #1 rst = 0;

      // Asynchronous reset mid-transfer.
      ack_mode = 2;
      wait_cyc("pre-rst cyc");
      #2 rst = 1;
      #1;
      chk("arst2 cyc", m_wb_cyc_o, 0);
      chk("arst2 stb", m_wb_stb_o, 0);
      chk("arst2 empty", empty, 1);
      chk("arst2 adr", m_wb_adr_o, adr);
      @(negedge clk); #1 rst = 0;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
